// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier controller that drives one shared HALF_W x HALF_W multiplier over four steps.
// Optional macro MULT16_SEQ_OPCNT_EN adds the op_count port, which counts completed result handoffs.
module mult16_seq_ctrl #(
   parameter int HALF_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*HALF_W-1:0]   in_a,
   input  logic [2*HALF_W-1:0]   in_b,
   output logic [HALF_W-1:0]     mul_a,
   output logic [HALF_W-1:0]     mul_b,
   input  logic [2*HALF_W-1:0]   mul_p,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*HALF_W-1:0]   out_p,
   output logic                  busy
`ifdef MULT16_SEQ_OPCNT_EN
   ,
   output logic [15:0]           op_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            step_q, step_d;
   logic [4*HALF_W-1:0]   acc_q, acc_d;
   logic [2*HALF_W-1:0]   a_q, a_d;
   logic [2*HALF_W-1:0]   b_q, b_d;
   logic [4*HALF_W-1:0]   out_p_q, out_p_d;
   logic [4*HALF_W-1:0]   prod_ext;
   logic [4*HALF_W-1:0]   prod_sh;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         out_p_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_p_q <= out_p_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      acc_d     = acc_q;
      a_d       = a_q;
      b_d       = b_q;
      out_p_d   = out_p_q;
      mul_a     = '0;
      mul_b     = '0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      prod_ext  = {{(2*HALF_W){1'b0}}, mul_p};
      prod_sh   = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               acc_d   = '0;
               step_d  = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            // Cross terms (hi*lo, lo*hi) share the same HALF_W weight.
            case (step_q)
               2'd0: begin
                  mul_a   = a_q[HALF_W-1:0];
                  mul_b   = b_q[HALF_W-1:0];
                  prod_sh = prod_ext;
               end
               2'd1: begin
                  mul_a   = a_q[2*HALF_W-1:HALF_W];
                  mul_b   = b_q[HALF_W-1:0];
                  prod_sh = prod_ext << HALF_W;
               end
               2'd2: begin
                  mul_a   = a_q[HALF_W-1:0];
                  mul_b   = b_q[2*HALF_W-1:HALF_W];
                  prod_sh = prod_ext << HALF_W;
               end
               default: begin
                  mul_a   = a_q[2*HALF_W-1:HALF_W];
                  mul_b   = b_q[2*HALF_W-1:HALF_W];
                  prod_sh = prod_ext << (2*HALF_W);
               end
            endcase
            acc_d  = acc_q + prod_sh;
            step_d = 2'(step_q + 2'd1);
            if (step_q == 2'd3) begin
               // Result register decouples out_p from the accumulator of the next op.
               out_p_d = acc_d;
               step_d  = 2'd0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out_p = out_p_q;
   assign busy  = (state_q != IDLE);

`ifdef MULT16_SEQ_OPCNT_EN
   logic [15:0] op_cnt_q, op_cnt_d;

   always_comb begin
      op_cnt_d = op_cnt_q;
      if (state_q == DONE && out_ready) begin
         op_cnt_d = 16'(op_cnt_q + 16'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_cnt_q <= '0;
      end else begin
         op_cnt_q <= op_cnt_d;
      end
   end

   assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed bench for mult16_seq_ctrl: table of operand/product vectors plus hold, reset and operand-change sequences.
module tb_mult16_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_p;
   logic        busy;
`ifdef MULT16_SEQ_OPCNT_EN
   logic [15:0] op_count;
`endif

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   // External shared multiplier: combinational product.
   assign mul_p = mul_a * mul_b;

   mult16_seq_ctrl #(.HALF_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
`ifdef MULT16_SEQ_OPCNT_EN
      ,
      .op_count  (op_count)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one operation; inputs change on negedges, outputs sampled on negedges.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                        input bit scramble);
      logic [15:0] pair [4];
      pair[0] = {a[7:0],  b[7:0]};
      pair[1] = {a[15:8], b[7:0]};
      pair[2] = {a[7:0],  b[15:8]};
      pair[3] = {a[15:8], b[15:8]};
      @(negedge clk);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b1;
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
         chk($sformatf("mul_pair_s%0d", s), {48'd0, mul_a, mul_b}, {48'd0, pair[s]});
         chk($sformatf("mul_flags_s%0d", s), {61'd0, in_ready, out_valid, busy}, 64'd1);
         if (scramble) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
         end
         @(negedge clk);
      end
      chk("done_valid", {63'd0, out_valid}, 64'd1);
      chk("done_out_p", {32'd0, out_p}, {32'd0, p});
      @(negedge clk);
      exp_cnt++;
      chk("after_handoff", {61'd0, in_ready, out_valid, busy}, 64'h4);
      chk("out_p_kept", {32'd0, out_p}, {32'd0, p});
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h5678, 32'h06260060};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2] = '{16'h0002, 16'h0003, 32'h00000006};
      vecs[3] = '{16'h00FF, 16'h0100, 32'h0000FF00};
      vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
      vecs[5] = '{16'h0100, 16'h0100, 32'h00010000};
      vecs[6] = '{16'hABCD, 16'h0001, 32'h0000ABCD};
      vecs[7] = '{16'h1000, 16'h1000, 32'h01000000};
      vecs[8] = '{16'h8000, 16'h0002, 32'h00010000};
      vecs[9] = '{16'h00FF, 16'h00FF, 32'h0000FE01};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'h4);
      chk("rst_out_p", {32'd0, out_p}, 64'd0);
      chk("rst_mul", {48'd0, mul_a, mul_b}, 64'd0);
      rst = 1'b0;
      exp_cnt = 0;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
      end

      // Result held while consumer stalls; in_valid held high must not be accepted.
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h0000; in_b = 16'hABCD; out_ready = 1'b0;
      @(negedge clk);
      in_a = 16'h1111; in_b = 16'h2222;
      repeat (4) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         chk("hold_flags", {61'd0, in_ready, out_valid, busy}, 64'h3);
         chk("hold_out_p", {32'd0, out_p}, 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      in_valid = 1'b0;
      chk("release_flags", {61'd0, in_ready, out_valid, busy}, 64'h4);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("single_handoff", {61'd0, in_ready, out_valid, busy}, 64'h4);
      end

      // Reset in MUL step 2 abandons the operation.
      in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0100;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_step2", {48'd0, mul_a, mul_b}, 64'hFF01);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      chk("midrst_flags", {61'd0, in_ready, out_valid, busy}, 64'h4);
      chk("midrst_out_p", {32'd0, out_p}, 64'd0);
      chk("midrst_mul", {48'd0, mul_a, mul_b}, 64'd0);
      do_op(16'h0002, 16'h0003, 32'h00000006, 1'b0);

      // Operand inputs changing during MUL must not matter.
      do_op(16'h8000, 16'h0002, 32'h00010000, 1'b1);

`ifdef MULT16_SEQ_OPCNT_EN
      chk("op_count", {48'd0, op_count}, 64'(exp_cnt));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
